// File: rtl/fb_arb_pkg.sv
// Shared types and frame geometry for the framebuffer scan arbiter.
package fb_arb_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, TURN} arb_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 400;
  localparam int FB_WORDS = H_ACTIVE * V_ACTIVE;

endpackage

// File: rtl/pix_fifo.sv
// First-word-fall-through pixel FIFO; head reads as zero while empty.
module pix_fifo #(
  parameter int DEPTH = 16,
  parameter int PIX_W = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [PIX_W-1:0]         push_data,
  output logic [PIX_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // NOTE: the storage array is deliberately left without reset; an empty
  // FIFO never exposes it because the head is forced to zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares the single-port framebuffer SRAM between linear scanout prefetch
// and a one-entry host write buffer.
module fb_scan_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W   = 18,
  parameter int PIX_W    = 15,
  parameter int DEPTH    = 16,
  parameter int HI_WATER = 12,
  parameter int FB_WORDS = fb_arb_pkg::FB_WORDS
) (
  input  logic                   input_clk,
  input  logic                   rst,
  input  logic                   frame_start,
  input  logic                   pix_pop,
  output logic [PIX_W-1:0]       pix_data,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] fifo_level,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [ADDR_W-1:0]      host_addr,
  input  logic [PIX_W-1:0]       host_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [PIX_W-1:0]       mem_wdata,
  input  logic [PIX_W-1:0]       mem_rdata,
  output logic                   mem_oe,
  output logic                   mem_we
);
  localparam int                LVL_W     = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] FETCH_END = ADDR_W'(FB_WORDS);

  arb_state_t        state;
  arb_state_t        nxt;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] buf_addr;
  logic [PIX_W-1:0]  buf_data;
  logic              buf_full;
  logic              buf_full_nxt;
  logic              buf_load;
  logic              inflight;
  logic              push;
  logic              room;
  logic              fetch_ok;
  logic              fifo_empty;
  logic              fifo_full;

  // The read strobed last cycle lands this edge, so it already owns a slot.
  assign inflight = (state == READ);
  assign push     = inflight && !frame_start;
  assign room     = !fifo_full && !(inflight && fifo_level == LVL_W'(DEPTH - 1));
  assign fetch_ok = !frame_start && (fetch_addr < FETCH_END) && room;
  assign buf_load = host_valid && host_ready;

  // NOTE: nxt gets a default before any branch so no latch is inferred.
  always_comb begin
    nxt = IDLE;
    if (buf_full && (int'(fifo_level) >= HI_WATER || !fetch_ok)) nxt = WRITE;
    else if (fetch_ok) nxt = (state == WRITE) ? TURN : READ;
  end

  assign buf_full_nxt = buf_load || (buf_full && nxt != WRITE);

  always_ff @(posedge input_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fetch_addr <= FETCH_END;
      buf_full   <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      host_ready <= 1'b0;
      underflow  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_oe     <= 1'b0;
      mem_we     <= 1'b0;
    end else begin
      state  <= nxt;
      mem_oe <= (nxt == READ);
      mem_we <= (nxt == WRITE);
      if (nxt == READ) mem_addr <= fetch_addr;
      if (nxt == WRITE) begin
        mem_addr  <= buf_addr;
        mem_wdata <= buf_data;
      end

      if (frame_start)       fetch_addr <= '0;
      else if (nxt == READ)  fetch_addr <= fetch_addr + ADDR_W'(1);

      buf_full   <= buf_full_nxt;
      host_ready <= !buf_full_nxt;
      if (buf_load) begin
        buf_addr <= host_addr;
        buf_data <= host_data;
      end

      if (frame_start)                 underflow <= 1'b0;
      else if (pix_pop && fifo_empty)  underflow <= 1'b1;
    end
  end

  pix_fifo #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_fifo (
    .clk       (input_clk),
    .rst       (rst),
    .push      (push),
    .pop       (pix_pop),
    .flush     (frame_start),
    .push_data (mem_rdata),
    .head      (pix_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Randomized bench for fb_scan_arbiter against a queue-based reference model.
module tb_fb_scan_arbiter;
  localparam int ADDR_W   = 18;
  localparam int PIX_W    = 15;
  localparam int DEPTH    = 16;
  localparam int HI_WATER = 12;
  localparam int FBW      = 300;

  logic              input_clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              pix_pop = 1'b0;
  logic [PIX_W-1:0]  pix_data;
  logic              underflow;
  logic [4:0]        fifo_level;
  logic              host_valid = 1'b0;
  logic              host_ready;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [PIX_W-1:0]  host_data = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic              mem_oe;
  logic              mem_we;

  fb_scan_arbiter #(
    .ADDR_W(ADDR_W), .PIX_W(PIX_W), .DEPTH(DEPTH), .HI_WATER(HI_WATER), .FB_WORDS(FBW)
  ) dut (
    .input_clk(input_clk), .rst(rst), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_data(pix_data), .underflow(underflow), .fifo_level(fifo_level),
    .host_valid(host_valid), .host_ready(host_ready), .host_addr(host_addr),
    .host_data(host_data), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_oe(mem_oe), .mem_we(mem_we)
  );

  always #5 input_clk = ~input_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // SRAM contents: unwritten words read back as their own low address bits.
  int sram [int];
  function automatic int sram_rd(input int a);
    return sram.exists(a) ? sram[a] : (a & 32'h7FFF);
  endfunction

  // Reference model. op: 0 idle, 1 read, 2 write, 3 turnaround.
  int q[$];
  int m_op, m_raddr, m_waddr, m_wdata, m_fetch, m_ba, m_bd;
  bit m_bfull, m_ready, m_uf;

  // Observation logs.
  int rd_log[$];
  int wr_addr_log[$];
  int wr_data_log[$];
  int turn_viol, both_hi, max_raddr, over_reads;
  bit prev_we;

  task automatic model_reset();
    q.delete();
    m_op = 0; m_raddr = 0; m_waddr = 0; m_wdata = 0; m_ba = 0; m_bd = 0;
    m_fetch = FBW; m_bfull = 0; m_ready = 0; m_uf = 0; prev_we = 0;
  endtask

  // One clock: compare at the negedge, drive inputs, advance the model.
  task automatic tick(input bit fs, input bit pop, input bit hv, input int ha, input int hd);
    int  rdata, lvl, op;
    bit  infl, f_ok;
    check("mem_oe", mem_oe, m_op == 1);
    check("mem_we", mem_we, m_op == 2);
    if (m_op == 1) check("rd_addr", mem_addr, m_raddr);
    if (m_op == 2) begin
      check("wr_addr", mem_addr, m_waddr);
      check("wr_data", mem_wdata, m_wdata);
    end
    check("fifo_level", fifo_level, q.size());
    check("pix_data", pix_data, (q.size() > 0) ? q[0] : 0);
    check("underflow", underflow, m_uf);
    check("host_ready", host_ready, m_ready);
    if (mem_oe) begin
      rd_log.push_back(int'(mem_addr));
      if (int'(mem_addr) > max_raddr) max_raddr = int'(mem_addr);
      if (int'(mem_addr) >= FBW) over_reads++;
      if (prev_we) turn_viol++;
    end
    if (mem_we) begin
      wr_addr_log.push_back(int'(mem_addr));
      wr_data_log.push_back(int'(mem_wdata));
    end
    if (mem_oe && mem_we) both_hi++;
    prev_we = mem_we;

    frame_start = fs; pix_pop = pop; host_valid = hv;
    host_addr = ADDR_W'(ha); host_data = PIX_W'(hd);
    mem_rdata = mem_oe ? PIX_W'(sram_rd(int'(mem_addr))) : '0;

    rdata = (m_op == 1) ? sram_rd(m_raddr) : 0;
    infl  = (m_op == 1);
    lvl   = q.size();
    f_ok  = !fs && m_fetch < FBW && lvl + int'(infl) + 1 <= DEPTH;
    op = 0;
    if (m_bfull && (lvl >= HI_WATER || !f_ok)) op = 2;
    else if (f_ok) op = (m_op == 2) ? 3 : 1;
    if (m_op == 2) sram[m_waddr] = m_wdata;
    if (fs) begin
      q.delete();
      m_uf = 0;
    end else begin
      if (pop) begin
        if (lvl > 0) void'(q.pop_front());
        else m_uf = 1;
      end
      if (infl) q.push_back(rdata);
    end
    if (op == 1) begin m_raddr = m_fetch; m_fetch++; end
    if (fs) m_fetch = 0;
    if (op == 2) begin m_waddr = m_ba; m_wdata = m_bd; m_bfull = 0; end
    if (hv && m_ready) begin m_bfull = 1; m_ba = ha; m_bd = hd; end
    m_ready = !m_bfull;
    m_op = op;

    @(posedge input_clk);
    @(negedge input_clk);
  endtask

  task automatic rand_ticks(input int n, input int fs_pm, input int pop_pct, input int hv_pct);
    for (int i = 0; i < n; i++)
      tick($urandom_range(999) < fs_pm, $urandom_range(99) < pop_pct,
           $urandom_range(99) < hv_pct, $urandom_range(FBW - 1), $urandom_range(32767));
  endtask

  // Asynchronous reset pulse checked mid-cycle, before any clock edge.
  task automatic reset_pulse();
    rst = 1'b1;
    #2;
    check("rst_oe", mem_oe, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_level", fifo_level, 0);
    check("rst_pix", pix_data, 0);
    check("rst_uf", underflow, 0);
    frame_start = 0; pix_pop = 0; host_valid = 0;
    model_reset();
    @(negedge input_clk);
    rst = 1'b0;
  endtask

  initial begin
    int bad, late_wr;
    model_reset();
    @(negedge input_clk);
    @(negedge input_clk);
    reset_pulse();

    // Fill after frame_start with no pops.
    rd_log.delete();
    tick(1, 0, 0, 0, 0);
    repeat (24) tick(0, 0, 0, 0, 0);
    check("fill_level", fifo_level, 16);
    check("fill_oe_idle", mem_oe, 0);
    check("fill_pix", pix_data, 0);
    check("fill_reads", rd_log.size(), 16);
    bad = 0;
    foreach (rd_log[i]) if (rd_log[i] != i) bad++;
    check("fill_seq", bad, 0);

    // Host write while the FIFO is full.
    wr_addr_log.delete(); wr_data_log.delete();
    tick(0, 0, 1, 'h100, 'h7FFF);
    check("hw_ready_low", host_ready, 0);
    repeat (4) tick(0, 0, 0, 0, 0);
    check("hw_count", wr_addr_log.size(), 1);
    if (wr_addr_log.size() == 1) begin
      check("hw_addr", wr_addr_log[0], 'h100);
      check("hw_data", wr_data_log[0], 'h7FFF);
    end
    check("hw_ready_back", host_ready, 1);

    // Alternating pops with host traffic; WRITE->READ must pass through TURN.
    for (int i = 0; i < 60; i++)
      tick(0, i[0], $urandom_range(99) < 40, $urandom_range(FBW - 1), $urandom_range(32767));

    // General random traffic including occasional frame restarts.
    rand_ticks(3000, 4, 60, 40);

    // A buffered write is discarded by reset.
    tick(0, 0, 1, 5, 'h1234);
    reset_pulse();
    wr_addr_log.delete();
    repeat (10) tick(0, 0, 0, 0, 0);
    check("rst_drop_write", wr_addr_log.size(), 0);

    // Underflow right after reset, cleared by frame_start.
    tick(0, 1, 0, 0, 0);
    check("uf_set", underflow, 1);
    check("uf_pix", pix_data, 0);
    tick(1, 0, 0, 0, 0);
    check("uf_clear", underflow, 0);

    // frame_start with a read in flight at level 10.
    for (int i = 0; i < 30 && fifo_level != 10; i++) tick(0, 0, 0, 0, 0);
    check("fs_lvl10", fifo_level, 10);
    check("fs_inflight", mem_oe, 1);
    tick(1, 0, 0, 0, 0);
    check("fs_flushed", fifo_level, 0);
    tick(0, 0, 0, 0, 0);
    check("fs_late_drop", fifo_level, 0);
    check("fs_restart_oe", mem_oe, 1);
    check("fs_restart_addr", mem_addr, 0);

    // End of frame: fetching stops at the last word, writes still serviced.
    tick(1, 0, 0, 0, 0);
    max_raddr = 0; over_reads = 0;
    rand_ticks(450, 0, 90, 15);
    wr_addr_log.delete();
    rand_ticks(250, 0, 90, 30);
    late_wr = wr_addr_log.size();
    check("eof_last_read", max_raddr, FBW - 1);
    check("eof_no_overrun", over_reads, 0);
    check("eof_writes_serviced", late_wr > 0, 1);
    check("turn_gap", turn_viol, 0);
    check("strobe_excl", both_hi, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
